four_mag: RTL and testbench

// - Registered 4-bit unsigned magnitude comparator.
// - Compares operands a and b and raises exactly one of three flags: greater, equal or less.
// - Leaf block used in datapath/control logic wherever a clean, registered ordering decision is needed.
// - Latency is one clock cycle.
//

---
 rtl/four_mag.sv | 47 ++++
 tb/tb_four_mag.sv | 130 +++++++++++++
 2 files changed

// File: rtl/four_mag.sv
// Registered magnitude comparator: one clock of latency, one-hot {c,d,e}
// flags after the first post-reset edge, all-zero flags while in reset.
module four_mag #(
    parameter int unsigned WIDTH  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c,
    output logic             d,
    output logic             e
);

    // Inverting both sign bits maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    localparam logic [WIDTH-1:0] SIGN_MASK =
        SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             gt_next;
    logic             eq_next;
    logic             lt_next;

    always_comb begin
        a_key   = a ^ SIGN_MASK;
        b_key   = b ^ SIGN_MASK;
        gt_next = a_key > b_key;
        eq_next = a_key == b_key;
        lt_next = a_key < b_key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= 1'b0;
            d <= 1'b0;
            e <= 1'b0;
        end else begin
            c <= gt_next;
            d <= eq_next;
            e <= lt_next;
        end
    end

endmodule

// File: tb/tb_four_mag.sv
// Bench for four_mag: unsigned and signed instances driven in parallel and
// checked against an integer-arithmetic reference after every clock edge.
module tb_four_mag;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       uc, ud, ue;
    logic       sc, sd, se;
    int         tests = 0;
    int         fails = 0;

    four_mag #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(uc), .d(ud), .e(ue)
    );

    four_mag #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(sc), .d(sd), .e(se)
    );

    always #5 clk = ~clk;

    // Reference ordering from plain integer values: {greater, equal, less}.
    function automatic logic [2:0] golden(input logic [3:0] x, input logic [3:0] y,
                                          input bit sgn);
        int xv;
        int yv;
        xv = int'(x);
        yv = int'(y);
        if (sgn) begin
            if (xv >= 8) xv = xv - 16;
            if (yv >= 8) yv = yv - 16;
        end
        return {xv > yv, xv == yv, xv < yv};
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a pair away from the edge, then check both instances just after it.
    task automatic step(input logic [3:0] x, input logic [3:0] y, input string tag);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        chk({tag, "_u"}, {uc, ud, ue}, golden(x, y, 1'b0));
        chk({tag, "_s"}, {sc, sd, se}, golden(x, y, 1'b1));
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;

        rst = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        #2;
        chk("reset_async_u", {uc, ud, ue}, 3'b000);
        chk("reset_async_s", {sc, sd, se}, 3'b000);
        @(posedge clk);
        #1;
        chk("reset_held_u", {uc, ud, ue}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_after_reset", {uc, ud, ue}, 3'b010);

        // Directed cases, including the lag between consecutive samples.
        step(4'b0001, 4'b0100, "lt_basic");
        step(4'b0101, 4'b0100, "gt_lag");
        step(4'b0011, 4'b0100, "lt_lag");
        step(4'b0001, 4'b1100, "sign_split");
        chk("sign_split_signed_gt", {sc, sd, se}, 3'b100);
        step(4'b0000, 4'b0000, "zero_eq");
        step(4'b1111, 4'b0000, "ones_vs_zero");
        step(4'b0000, 4'b1111, "zero_vs_ones");
        step(4'b1111, 4'b1111, "ones_eq");

        // Input changes between edges must not reach the flags.
        @(negedge clk);
        a = 4'b0000;
        b = 4'b1010;
        #1;
        chk("hold_between_edges", {uc, ud, ue}, 3'b010);

        // Reset between edges clears at once and discards the pending compare.
        @(negedge clk);
        a = 4'b1000;
        b = 4'b0001;
        rst = 1'b1;
        #1;
        chk("midrst_clear_u", {uc, ud, ue}, 3'b000);
        chk("midrst_clear_s", {sc, sd, se}, 3'b000);
        @(posedge clk);
        #1;
        chk("midrst_held", {uc, ud, ue}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_release_u", {uc, ud, ue}, golden(4'b1000, 4'b0001, 1'b0));
        chk("after_rst_release_s", {sc, sd, se}, golden(4'b1000, 4'b0001, 1'b1));

        // Exhaustive sweep with one-hot check.
        for (int i = 0; i < 256; i++) begin
            step(4'(i >> 4), 4'(i), "sweep");
            chk("onehot_u", {2'b00, $onehot({uc, ud, ue})}, 3'b001);
            chk("onehot_s", {2'b00, $onehot({sc, sd, se})}, 3'b001);
        end

        // Random pairs.
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            step(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
